// File: rtl/ber_checker.sv
// ber_checker: self-synchronizing PRBS9 (x^9+x^5+1) bit-error-rate checker for
// one slicer branch (I or Q) of the adaptive equalizer.
//
// Ports:
//   clk        system clock
//   i_reset    asynchronous reset, active-low
//   i_sym      slicer symbol word; only the sign bit (MSB) is used (-1 -> bit 1)
//   i_valid    symbol strobe; nothing advances while low
//   i_clear    synchronous clear of the bit/error counters (FSM unaffected)
//   o_lock     high while the checker is locked to the PRBS
//   o_bit_cnt  bits checked while locked (saturating, freezes both counters)
//   o_err_cnt  bit errors seen while locked
//   o_lol      one-cycle pulse on every loss of lock
module ber_checker #(
    parameter int unsigned NBT_SYM  = 12,
    parameter int unsigned NB_CNT   = 64,
    parameter int unsigned SYNC_WIN = 128,
    parameter int unsigned SYNC_THR = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NBT_SYM-1:0] i_sym,
    input  logic               i_valid,
    input  logic               i_clear,
    output logic               o_lock,
    output logic [NB_CNT-1:0]  o_bit_cnt,
    output logic [NB_CNT-1:0]  o_err_cnt,
    output logic               o_lol
);

    localparam int unsigned LFSR_W = 9;
    localparam int unsigned LD_W   = 4;
    localparam int unsigned WIN_W  = $clog2(SYNC_WIN);
    localparam int unsigned ERR_W  = $clog2(SYNC_WIN + 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LFSR_W-1:0]  lfsr, lfsr_nxt;
    logic [LD_W-1:0]    ld_cnt, ld_cnt_nxt;
    logic [WIN_W-1:0]   win, win_nxt;
    logic [ERR_W-1:0]   err_win, err_win_nxt;

    logic               rx_bit;
    logic               pred;
    logic               bit_err;
    logic [ERR_W-1:0]   err_sum;
    logic               win_end;
    logic               win_pass;
    logic [LFSR_W-1:0]  load_shift;
    logic               sat;
    logic               lock_d;
    logic               lol_d;
    logic               cnt_en;
    logic               unused_sym_bits;

    // Decision bit and local PRBS prediction
    assign rx_bit     = i_sym[NBT_SYM-1];
    assign pred       = lfsr[8] ^ lfsr[4];
    assign bit_err    = rx_bit ^ pred;
    assign err_sum    = err_win + ERR_W'(bit_err);
    assign win_end    = (win == WIN_W'(SYNC_WIN - 1));
    assign win_pass   = (err_sum <= ERR_W'(SYNC_THR));
    assign load_shift = {lfsr[LFSR_W-2:0], rx_bit};
    assign sat        = &o_bit_cnt;

    assign unused_sym_bits = ^i_sym[NBT_SYM-2:0];

    // State register
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and sync datapath logic
    always_comb begin
        state_nxt   = state;
        lfsr_nxt    = lfsr;
        ld_cnt_nxt  = ld_cnt;
        win_nxt     = win;
        err_win_nxt = err_win;
        if (i_valid) begin
            case (state)
                ST_LOAD: begin
                    lfsr_nxt = load_shift;
                    if (ld_cnt == LD_W'(LFSR_W - 1)) begin
                        ld_cnt_nxt = '0;
                        // An all-zero seed would lock the LFSR at zero forever
                        if (load_shift != '0) begin
                            state_nxt   = ST_SYNC;
                            win_nxt     = '0;
                            err_win_nxt = '0;
                        end
                    end else begin
                        ld_cnt_nxt = ld_cnt + LD_W'(1);
                    end
                end
                ST_SYNC, ST_LOCKED: begin
                    lfsr_nxt = {lfsr[LFSR_W-2:0], pred};
                    if (win_end) begin
                        win_nxt     = '0;
                        err_win_nxt = '0;
                        if (win_pass) begin
                            state_nxt = ST_LOCKED;
                        end else begin
                            state_nxt  = ST_LOAD;
                            ld_cnt_nxt = '0;
                        end
                    end else begin
                        win_nxt     = win + WIN_W'(1);
                        err_win_nxt = err_sum;
                    end
                end
                default: begin
                    state_nxt  = ST_LOAD;
                    ld_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output decode (registered below)
    always_comb begin
        lock_d = 1'b0;
        lol_d  = 1'b0;
        cnt_en = 1'b0;
        lock_d = (state_nxt == ST_LOCKED);
        lol_d  = (state == ST_LOCKED) && i_valid && win_end && !win_pass;
        cnt_en = (state == ST_LOCKED) && i_valid && !sat;
    end

    // LFSR and window bookkeeping
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            lfsr    <= '0;
            ld_cnt  <= '0;
            win     <= '0;
            err_win <= '0;
        end else begin
            lfsr    <= lfsr_nxt;
            ld_cnt  <= ld_cnt_nxt;
            win     <= win_nxt;
            err_win <= err_win_nxt;
        end
    end

    // Registered outputs; counters hold across loss of lock
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_lock    <= 1'b0;
            o_lol     <= 1'b0;
            o_bit_cnt <= '0;
            o_err_cnt <= '0;
        end else begin
            o_lock <= lock_d;
            o_lol  <= lol_d;
            if (i_clear) begin
                o_bit_cnt <= '0;
                o_err_cnt <= '0;
            end else if (cnt_en) begin
                o_bit_cnt <= o_bit_cnt + NB_CNT'(1);
                o_err_cnt <= o_err_cnt + NB_CNT'(bit_err);
            end
        end
    end

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: clean lock, sparse errors, loss/regain of lock,
// counter saturation and clear (4-bit instance), async reset, all-zero input.
module tb_ber_checker;

    localparam int unsigned NBT_SYM = 12;

    logic               clk;
    logic               rst_n;
    logic [NBT_SYM-1:0] sym;
    logic               valid;
    logic               clr;
    logic               clr2;

    logic               lock, lol;
    logic [63:0]        bit_cnt, err_cnt;
    logic               lock2, lol2;
    logic [3:0]         bit_cnt2, err_cnt2;

    int                 total;
    int                 bad;
    int                 lol_seen;
    logic [8:0]         gen;
    logic               b;

    ber_checker #(.NBT_SYM(NBT_SYM), .NB_CNT(64), .SYNC_WIN(128), .SYNC_THR(8)) dut (
        .clk       (clk),
        .i_reset   (rst_n),
        .i_sym     (sym),
        .i_valid   (valid),
        .i_clear   (clr),
        .o_lock    (lock),
        .o_bit_cnt (bit_cnt),
        .o_err_cnt (err_cnt),
        .o_lol     (lol)
    );

    ber_checker #(.NBT_SYM(NBT_SYM), .NB_CNT(4), .SYNC_WIN(128), .SYNC_THR(8)) dut_sat (
        .clk       (clk),
        .i_reset   (rst_n),
        .i_sym     (sym),
        .i_valid   (valid),
        .i_clear   (clr2),
        .o_lock    (lock2),
        .o_bit_cnt (bit_cnt2),
        .o_err_cnt (err_cnt2),
        .o_lol     (lol2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lol) lol_seen <= lol_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One symbol per 4 clocks; returns 1 time unit after the sampling edge
    task automatic send(input logic bit_in, input logic clr2_in);
        repeat (3) tick();
        sym   = bit_in ? 12'hF00 : 12'h100;
        valid = 1'b1;
        clr2  = clr2_in;
        tick();
        valid = 1'b0;
        clr2  = 1'b0;
    endtask

    task automatic next_prbs(output logic nb);
        nb  = gen[8] ^ gen[4];
        gen = {gen[7:0], nb};
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        lol_seen = 0;
        gen      = 9'h1AA;
        rst_n    = 1'b0;
        sym      = '0;
        valid    = 1'b0;
        clr      = 1'b0;
        clr2     = 1'b0;
        repeat (3) tick();

        check("rst_lock", 64'(lock), 64'd0);
        check("rst_bit", bit_cnt, 64'd0);
        check("rst_err", err_cnt, 64'd0);
        check("rst_lol", 64'(lol), 64'd0);
        check("rst_bit_sat", 64'(bit_cnt2), 64'd0);
        rst_n = 1'b1;

        // Clean PRBS: lock exactly on valid 9+128
        for (int i = 0; i < 136; i++) begin
            next_prbs(b);
            send(b, 1'b0);
            if (i == 8) check("lock_after_load", 64'(lock), 64'd0);
        end
        check("lock_before_137", 64'(lock), 64'd0);
        check("bit_before_lock", bit_cnt, 64'd0);
        next_prbs(b);
        send(b, 1'b0);
        check("lock_at_137", 64'(lock), 64'd1);
        check("bit_at_lock", bit_cnt, 64'd0);
        for (int i = 0; i < 1000; i++) begin
            next_prbs(b);
            send(b, 1'b0);
        end
        check("clean_bit", bit_cnt, 64'd1000);
        check("clean_err", err_cnt, 64'd0);
        check("clean_lock", 64'(lock), 64'd1);
        check("sat_bit", 64'(bit_cnt2), 64'd15);
        check("sat_err", 64'(err_cnt2), 64'd0);

        // One error per 100 bits; clear the 4-bit instance on the first bit
        for (int i = 0; i < 1000; i++) begin
            next_prbs(b);
            if (i % 100 == 99) b = ~b;
            send(b, i == 0);
            if (i == 0) begin
                check("clr_bit", 64'(bit_cnt2), 64'd0);
                check("clr_err", 64'(err_cnt2), 64'd0);
            end
            if (i == 1) check("after_clr_bit", 64'(bit_cnt2), 64'd1);
        end
        check("sparse_bit", bit_cnt, 64'd2000);
        check("sparse_err", err_cnt, 64'd10);
        check("sparse_lock", 64'(lock), 64'd1);
        check("sparse_no_lol", 64'(lol_seen), 64'd0);
        check("resat_bit", 64'(bit_cnt2), 64'd15);
        check("resat_err", 64'(err_cnt2), 64'd0);

        // Corrupt data: the current window (48 bits left) fails
        for (int i = 0; i < 48; i++) begin
            next_prbs(b);
            send(~b, 1'b0);
            if (i == 46) begin
                check("lock_before_lol", 64'(lock), 64'd1);
                check("no_lol_early", 64'(lol), 64'd0);
            end
        end
        check("lol_pulse", 64'(lol), 64'd1);
        check("lock_dropped", 64'(lock), 64'd0);
        check("held_bit", bit_cnt, 64'd2048);
        check("held_err", err_cnt, 64'd58);
        tick();
        check("lol_one_cycle", 64'(lol), 64'd0);

        // Restore PRBS: relock after 9+128, counters resume from held values
        for (int i = 0; i < 136; i++) begin
            next_prbs(b);
            send(b, 1'b0);
        end
        check("relock_not_yet", 64'(lock), 64'd0);
        check("relock_hold_bit", bit_cnt, 64'd2048);
        next_prbs(b);
        send(b, 1'b0);
        check("relock", 64'(lock), 64'd1);
        for (int i = 0; i < 100; i++) begin
            next_prbs(b);
            send(b, 1'b0);
        end
        check("resume_bit", bit_cnt, 64'd2148);
        check("resume_err", err_cnt, 64'd58);
        check("lol_count", 64'(lol_seen), 64'd1);

        // Async reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_lock", 64'(lock), 64'd0);
        check("arst_bit", bit_cnt, 64'd0);
        check("arst_err", err_cnt, 64'd0);
        check("arst_lol", 64'(lol), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // All +1.0 (zero bits): never leaves LOAD
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 1'b0);
            if (i == 136) check("zero_lock_137", 64'(lock), 64'd0);
        end
        check("zero_lock", 64'(lock), 64'd0);
        check("zero_bit", bit_cnt, 64'd0);
        check("zero_lol_count", 64'(lol_seen), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
